mdu_iter: RTL

Parametrised iterative multiply/divide unit for the EX stage of the pipelined CPU. It takes one multiply or divide request, runs a radix-2 shift-add or restoring-division loop over `WIDTH` cycles, and writes the result to internal HI/LO registers. While running it holds `busy` high, which the hazard logic uses to stall the pipeline. HI/LO are readable at all times for mfhi/mflo and writable for mthi/mtlo.

---
 rtl/mdu_iter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 shift-add multiplier / restoring divider with HI/LO.
// Build option: define MDU_DIV_EN to include DIV/DIVU; without it only MULT/MULTU exist.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               is_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic               sign_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fix_hi, fix_lo;
    logic               fix_dz;
`ifdef MDU_DIV_EN
    logic               is_div_q;
    logic               rsign_q;
    logic               dz_q;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH:0]     div_sh, div_diff;
`endif

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    // Signed ops work on magnitudes; the sign is restored in FIX
    assign is_signed = ~op[0];
    assign a_mag     = neg_w(a, is_signed & a[WIDTH-1]);
    assign b_mag     = neg_w(b, is_signed & b[WIDTH-1]);

`ifdef MDU_DIV_EN
    assign accept = (state == S_IDLE) && start && !flush;
`else
    assign accept = (state == S_IDLE) && start && !flush && !op[1];
`endif

    assign busy = (state != S_IDLE);

    // Next-state logic; flush aborts anything in flight
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  if (cnt == LAST_ITER) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush && (state != S_IDLE)) state_nxt = S_IDLE;
    end

    // State register and iteration counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= '0;
            else if (state == S_CALC)
                cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef MDU_DIV_EN
    // Restoring step: remainder shifted left with next dividend bit, trial-subtract divisor
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb};
`endif

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            opb    <= b_mag;
`ifdef MDU_DIV_EN
            is_div_q <= op[1];
            rsign_q  <= is_signed & a[WIDTH-1];
            dz_q     <= op[1] && (b == '0);
            a_raw    <= a;
            acc      <= op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
`else
            acc      <= '0;
`endif
        end else if (state == S_CALC) begin
`ifdef MDU_DIV_EN
            if (is_div_q) begin
                if (!div_diff[WIDTH])
                    acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                else
                    acc <= {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else
`endif
            begin
                if (opb[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
        end
    end

    // Sign correction and HI/LO selection for the FIX cycle
    always_comb begin
        prod_fix = neg_2w(acc, sign_q);
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        fix_dz   = 1'b0;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
            if (dz_q) begin
                fix_lo = '1;
                fix_hi = a_raw;
                fix_dz = 1'b1;
            end else begin
                fix_lo = neg_w(acc[WIDTH-1:0], sign_q);
                fix_hi = neg_w(acc[2*WIDTH-1:WIDTH], rsign_q);
            end
        end
`endif
    end

    // HI/LO: result write at FIX, mthi/mtlo only while idle; done/dz pulse with the write
    always_ff @(posedge clk) begin
        if (rst) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
            dz   <= 1'b0;
        end else begin
            done <= 1'b0;
            dz   <= 1'b0;
            if ((state == S_FIX) && !flush) begin
                hi   <= fix_hi;
                lo   <= fix_lo;
                done <= 1'b1;
                dz   <= fix_dz;
            end else if (state == S_IDLE) begin
                if (hi_we) hi <= wdata;
                if (lo_we) lo <= wdata;
            end
        end
    end

endmodule
